ulpi_ctl: RTL and testbench
===========================

# ulpi_ctl

Transaction controller in front of the ULPI AXI-Stream bridge. It arbitrates the bridge's single TX stream between USB packet transmission and PHY register access. It builds ULPI TX CMD bytes (transmit, register write, register read) and captures register read data returned on the RX stream. It also decodes RXCMD bytes into line-state status for the link layer.

## Interface
- REG_TIMEOUT, 255: cycles REG_RWAIT waits for read data before flagging an error (8-bit counter; legal 1..255).
- clk  in  1  clock (ULPI 60 MHz domain)
- rst  in  1  reset, asynchronous, active-high
- pkt_tvalid / pkt_tready  in / out  1  USB packet stream handshake
- pkt_tdata  in  8  packet byte; first byte is the PID
- pkt_tlast  in  1  last packet byte
- reg_req  in  1  register request, level, held until reg_ack
- reg_we  in  1  1 = write, 0 = read
- reg_addr  in  6  PHY register address (immediate addressing only)
- reg_wdata  in  8  write data
- reg_ack  out  1  one-cycle completion pulse
- reg_rdata  out  8  read data, valid with reg_ack
- reg_err  out  1  read timed out, valid with reg_ack
- tx_tvalid / tx_tready  out / in  1  handshake to the bridge TX slave
- tx_tdata  out  8  byte to the bridge
- tx_tlast  out  1  last byte; bridge asserts STP
- rx_tvalid  in  1  bridge RX beat (dir high, not turnaround)
- rx_tdata  in  8  RX byte
- rx_tuser  in  2  {rxactive, phydata}
- linestate  out  2  last RXCMD[1:0]
- vbus_state  out  2  last RXCMD[3:2]
- rx_event  out  2  last RXCMD[5:4]

## Operation
- FSM states: IDLE, PKT, REG_WCMD, REG_WDATA, REG_RCMD, REG_RWAIT, REG_ACK.
- Start conditions in IDLE:
  - A transaction starts only in a cycle with rx_tvalid = 0.
  - If pkt_tvalid is high, go to PKT. Packets win over registers because USB turnaround is timing-critical.
  - Otherwise, if reg_req is high, go to REG_WCMD when reg_we = 1, or to REG_RCMD when reg_we = 0.
- PKT: combinational passthrough.
  - tx_tvalid = pkt_tvalid, pkt_tready = tx_tready, tx_tlast = pkt_tlast.
  - tx_tdata = {4'h4, pkt_tdata[3:0]} on the first beat (TX CMD), else pkt_tdata.
  - An accepted beat with tlast returns to IDLE.
- REG_WCMD: drive byte {2'b10, reg_addr} with tlast = 0. On accept, go to REG_WDATA.
- REG_WDATA: drive reg_wdata with tlast = 1. On accept, go to REG_ACK.
- REG_RCMD: drive byte {2'b11, reg_addr} with tlast = 0. On accept, go to REG_RWAIT.
- REG_RWAIT:
  - The first rx_tvalid beat with rx_tuser[0] = 1 is register data. Latch it into reg_rdata and go to REG_ACK.
  - A beat with rx_tuser[0] = 0 (USB data, the PHY aborted) is ignored.
- REG_ACK: pulse reg_ack for one cycle, then go to IDLE. reg_req is not re-sampled until IDLE.
- TX stream rule: once tx_tvalid is raised, the beat is held stable until accepted. No abort at mid-beat.
- RXCMD decode: any rx_tvalid beat with tuser[0] = 1, outside REG_RWAIT's captured beat, updates linestate, vbus_state and rx_event.
- Registered outputs: reg_ack, reg_rdata, reg_err, status fields. Outside PKT, tx_* are registered.
- Reset values: tx_tvalid = 0, tx_tdata = 0, tx_tlast = 0, pkt_tready = 0, reg_ack = 0, reg_rdata = 0, reg_err = 0, linestate = 0, vbus_state = 0, rx_event = 0, FSM = IDLE.
- Reset asserted mid-transaction abandons it without an ack. The requester must re-issue.

## Timing
- reg_req seen high in IDLE at cycle N: command byte on tx_tdata at N+1.
- Register write: reg_ack high the cycle after the data beat is accepted.
- Register read: reg_ack high the cycle after the rdata beat.
- Packets: zero added latency per byte after the IDLE→PKT decision cycle. pkt_tready is low in that decision cycle.
- Back-to-back: IDLE lasts at least one cycle between transactions.
- Simultaneous pkt_tvalid and reg_req: packet first; the register op starts after the packet's tlast.

## Configuration
- ULPI_CTL_REG_TIMEOUT_EN defined:
  - An 8-bit counter runs in REG_RWAIT.
  - After REG_TIMEOUT cycles with no data, go to REG_ACK with reg_err = 1 and reg_rdata = 0.
- Undefined: REG_RWAIT waits indefinitely, reg_err is tied 0, and REG_TIMEOUT is unused.

## Structure
- The shared ulpi_pkg holds:
  - TX CMD prefix constants: TXCMD_TRANSMIT = 2'b01, TXCMD_REGW = 2'b10, TXCMD_REGR = 2'b11.
  - The RXCMD field struct.
  - The ulpi_ctl state enum.
- One sub-module, ulpi_rxcmd_decode: registers the RXCMD fields from the RX beat.

## Test plan
- Write reg 0x0A ← 0x55 → tx beats 0x8A (tlast 0), then 0x55 (tlast 1); reg_ack the following cycle.
- Read reg 0x16 → beat 0xD6 (tlast 0); RX beat 0x3C with tuser 2'b01 → reg_rdata 0x3C, reg_ack, reg_err 0. linestate is unchanged by this beat.
- Packet 0xC3, 0x11, 0x22 (tlast on last) → tx beats 0x43, 0x11, 0x22 with tlast on 0x22; random tx_tready stalls preserve order.
- pkt_tvalid and reg_req rise in the same cycle → full packet first, then register command; no interleaving.
- ULPI_CTL_REG_TIMEOUT_EN, REG_TIMEOUT = 16, read with no RX → reg_ack with reg_err = 1 after 16 REG_RWAIT cycles. Without the macro, no ack within 1000 cycles.
- RX beat 0x4D, tuser 2'b01, in IDLE → linestate 2'b01, vbus_state 2'b11, rx_event 2'b00. Asserting rst in REG_WDATA → tx_tvalid 0 immediately, no reg_ack.

Source files
------------

// File: rtl/ulpi_pkg.sv
// Shared ULPI definitions: TX CMD prefixes, RXCMD byte layout and the
// ulpi_ctl state encoding.
package ulpi_pkg;

  localparam logic [1:0] TXCMD_TRANSMIT = 2'b01;
  localparam logic [1:0] TXCMD_REGW     = 2'b10;
  localparam logic [1:0] TXCMD_REGR     = 2'b11;

  typedef struct packed {
    logic [1:0] alt_int;
    logic [1:0] rx_event;
    logic [1:0] vbus_state;
    logic [1:0] linestate;
  } rxcmd_t;

  typedef enum logic [2:0] {
    IDLE, PKT, REG_WCMD, REG_WDATA, REG_RCMD, REG_RWAIT, REG_ACK
  } ulpi_ctl_state_t;

endpackage

// File: rtl/ulpi_rxcmd_decode.sv
// Holds the line-state, VBUS and RX event fields of the most recent RXCMD byte.
module ulpi_rxcmd_decode (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd,
  input  logic [7:0] rxcmd,
  output logic [1:0] linestate,
  output logic [1:0] vbus_state,
  output logic [1:0] rx_event
);
  import ulpi_pkg::*;

  rxcmd_t     cmd;
  logic [1:0] unused_alt;

  assign cmd        = rxcmd_t'(rxcmd);
  assign unused_alt = cmd.alt_int;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      linestate  <= 2'b00;
      vbus_state <= 2'b00;
      rx_event   <= 2'b00;
    end else if (upd) begin
      linestate  <= cmd.linestate;
      vbus_state <= cmd.vbus_state;
      rx_event   <= cmd.rx_event;
    end
  end

endmodule

// File: rtl/ulpi_ctl.sv
// ULPI transaction controller: shares the bridge TX stream between USB packets
// and PHY register access. Read timeout is built when ULPI_CTL_REG_TIMEOUT_EN is defined.
module ulpi_ctl #(
  parameter int unsigned REG_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_tvalid,
  output logic       pkt_tready,
  input  logic [7:0] pkt_tdata,
  input  logic       pkt_tlast,
  input  logic       reg_req,
  input  logic       reg_we,
  input  logic [5:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic       reg_ack,
  output logic [7:0] reg_rdata,
  output logic       reg_err,
  output logic       tx_tvalid,
  input  logic       tx_tready,
  output logic [7:0] tx_tdata,
  output logic       tx_tlast,
  input  logic       rx_tvalid,
  input  logic [7:0] rx_tdata,
  input  logic [1:0] rx_tuser,
  output logic [1:0] linestate,
  output logic [1:0] vbus_state,
  output logic [1:0] rx_event
);
  import ulpi_pkg::*;

  ulpi_ctl_state_t state, state_n;
  logic       tx_valid_r, tx_valid_n;
  logic [7:0] tx_data_r, tx_data_n;
  logic       tx_last_r, tx_last_n;
  logic       first_r, first_n;
  logic       ack_n;
  logic [7:0] rdata_n;
  logic       rx_reg_beat;
  logic       unused_tuser;

  assign rx_reg_beat  = rx_tvalid && rx_tuser[0];
  assign unused_tuser = rx_tuser[1];

`ifdef ULPI_CTL_REG_TIMEOUT_EN
  logic [7:0] tmo_cnt, tmo_cnt_n;
  logic       err_r, err_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= 8'd0;
      err_r   <= 1'b0;
    end else begin
      tmo_cnt <= tmo_cnt_n;
      err_r   <= err_n;
    end
  end

  assign reg_err = err_r;
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(REG_TIMEOUT);
  assign reg_err        = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    tx_valid_n = tx_valid_r;
    tx_data_n  = tx_data_r;
    tx_last_n  = tx_last_r;
    first_n    = first_r;
    ack_n      = 1'b0;
    rdata_n    = reg_rdata;
`ifdef ULPI_CTL_REG_TIMEOUT_EN
    err_n      = err_r;
    tmo_cnt_n  = tmo_cnt;
`endif
    case (state)
      // Never start while the PHY owns the bus; packets beat register ops.
      IDLE: begin
        if (!rx_tvalid && pkt_tvalid) begin
          state_n = PKT;
          first_n = 1'b1;
        end else if (!rx_tvalid && reg_req) begin
          state_n    = reg_we ? REG_WCMD : REG_RCMD;
          tx_valid_n = 1'b1;
          tx_data_n  = {(reg_we ? TXCMD_REGW : TXCMD_REGR), reg_addr};
          tx_last_n  = 1'b0;
        end
      end
      PKT: begin
        if (pkt_tvalid && tx_tready) begin
          first_n = 1'b0;
          if (pkt_tlast) state_n = IDLE;
        end
      end
      REG_WCMD: begin
        if (tx_tready) begin
          state_n   = REG_WDATA;
          tx_data_n = reg_wdata;
          tx_last_n = 1'b1;
        end
      end
      REG_WDATA: begin
        if (tx_tready) begin
          state_n    = REG_ACK;
          tx_valid_n = 1'b0;
          tx_data_n  = 8'h00;
          tx_last_n  = 1'b0;
          ack_n      = 1'b1;
`ifdef ULPI_CTL_REG_TIMEOUT_EN
          err_n      = 1'b0;
`endif
        end
      end
      REG_RCMD: begin
        if (tx_tready) begin
          state_n    = REG_RWAIT;
          tx_valid_n = 1'b0;
          tx_data_n  = 8'h00;
`ifdef ULPI_CTL_REG_TIMEOUT_EN
          tmo_cnt_n  = 8'd0;
`endif
        end
      end
      // USB data beats (tuser[0] = 0) are ignored while waiting for the read byte.
      REG_RWAIT: begin
        if (rx_reg_beat) begin
          state_n = REG_ACK;
          ack_n   = 1'b1;
          rdata_n = rx_tdata;
`ifdef ULPI_CTL_REG_TIMEOUT_EN
          err_n   = 1'b0;
        end else if (tmo_cnt == 8'(REG_TIMEOUT - 1)) begin
          state_n = REG_ACK;
          ack_n   = 1'b1;
          rdata_n = 8'h00;
          err_n   = 1'b1;
        end else begin
          tmo_cnt_n = tmo_cnt + 8'd1;
`endif
        end
      end
      REG_ACK: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx_valid_r <= 1'b0;
      tx_data_r  <= 8'h00;
      tx_last_r  <= 1'b0;
      first_r    <= 1'b0;
      reg_ack    <= 1'b0;
      reg_rdata  <= 8'h00;
    end else begin
      state      <= state_n;
      tx_valid_r <= tx_valid_n;
      tx_data_r  <= tx_data_n;
      tx_last_r  <= tx_last_n;
      first_r    <= first_n;
      reg_ack    <= ack_n;
      reg_rdata  <= rdata_n;
    end
  end

  // Packets pass straight through; the PID byte becomes the TX CMD.
  assign tx_tvalid  = (state == PKT) ? pkt_tvalid : tx_valid_r;
  assign tx_tlast   = (state == PKT) ? pkt_tlast  : tx_last_r;
  assign tx_tdata   = (state != PKT) ? tx_data_r :
                      first_r ? {TXCMD_TRANSMIT, 2'b00, pkt_tdata[3:0]} : pkt_tdata;
  assign pkt_tready = (state == PKT) && tx_tready;

  ulpi_rxcmd_decode u_rxcmd (
    .clk        (clk),
    .rst        (rst),
    .upd        (rx_reg_beat && (state != REG_RWAIT)),
    .rxcmd      (rx_tdata),
    .linestate  (linestate),
    .vbus_state (vbus_state),
    .rx_event   (rx_event)
  );

endmodule

// File: tb/tb_ulpi_ctl.sv
// Scoreboard bench for ulpi_ctl: randomized packets, register ops and RXCMDs
// checked against a transaction-level model of expected TX beats and acks.
module tb_ulpi_ctl;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       pkt_tvalid, pkt_tready, pkt_tlast;
  logic [7:0] pkt_tdata;
  logic       reg_req, reg_we, reg_ack, reg_err;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;
  logic       tx_tvalid, tx_tready, tx_tlast;
  logic [7:0] tx_tdata;
  logic       rx_tvalid;
  logic [7:0] rx_tdata;
  logic [1:0] rx_tuser;
  logic [1:0] linestate, vbus_state, rx_event;

  always #5 clk = ~clk;

  ulpi_ctl #(.REG_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .pkt_tvalid(pkt_tvalid), .pkt_tready(pkt_tready), .pkt_tdata(pkt_tdata), .pkt_tlast(pkt_tlast),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata), .tx_tlast(tx_tlast),
    .rx_tvalid(rx_tvalid), .rx_tdata(rx_tdata), .rx_tuser(rx_tuser),
    .linestate(linestate), .vbus_state(vbus_state), .rx_event(rx_event)
  );

  typedef struct { logic [7:0] data; logic last; logic ack_next; } beat_t;
  typedef struct { logic [7:0] rdata; logic err; logic is_read; } ack_t;

  beat_t      exp_tx[$];
  ack_t       exp_ack[$];
  int         checks = 0;
  int         passes = 0;
  int         rdy_mode = 1;
  logic [1:0] m_ls = 2'b00, m_vb = 2'b00, m_ev = 2'b00;
  logic [7:0] pkt_buf [16];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_beat(input logic [7:0] d, input logic last, input logic ack_next);
    beat_t b;
    b.data = d; b.last = last; b.ack_next = ack_next;
    exp_tx.push_back(b);
  endtask

  task automatic push_ack(input logic [7:0] rdata, input logic err, input logic is_read);
    ack_t a;
    a.rdata = rdata; a.err = err; a.is_read = is_read;
    exp_ack.push_back(a);
  endtask

  task automatic check_status();
    checkOutput("linestate", linestate, m_ls);
    checkOutput("vbus_state", vbus_state, m_vb);
    checkOutput("rx_event", rx_event, m_ev);
  endtask

  // Bridge back-pressure: random stalls, always ready, or driven by hand.
  initial begin
    tx_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) tx_tready = ($urandom_range(0, 3) != 0);
      else if (rdy_mode == 1) tx_tready = 1'b1;
    end
  end

  // Monitor: every accepted TX beat and every reg_ack pops the scoreboard.
  initial begin
    beat_t b;
    ack_t  a;
    bit    ack_due;
    ack_due = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) ack_due = 1'b0;
      else begin
        if (ack_due) begin
          checkOutput("write_ack_timing", reg_ack, 1);
          ack_due = 1'b0;
        end
        if (tx_tvalid && tx_tready) begin
          if (exp_tx.size() == 0) begin
            checks++;
            $display("[TB] FAIL tx_extra: got beat 0x%0h, expected no beat", tx_tdata);
          end else begin
            b = exp_tx.pop_front();
            checkOutput("tx_beat", {tx_tlast, tx_tdata}, {b.last, b.data});
            ack_due = b.ack_next;
          end
        end
        if (reg_ack) begin
          if (exp_ack.size() == 0) begin
            checks++;
            $display("[TB] FAIL ack_extra: got reg_ack 1, expected 0");
          end else begin
            a = exp_ack.pop_front();
            checkOutput("reg_err", reg_err, a.err);
            if (a.is_read) checkOutput("reg_rdata", reg_rdata, a.rdata);
          end
        end
      end
    end
  end

  task automatic wait_ack(input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk); n++;
      if (reg_ack === 1'b1 || n >= 500) break;
    end
    if (reg_ack !== 1'b1) begin
      checks++;
      $display("[TB] FAIL %s: got no reg_ack, expected one within 500 cycles", name);
    end
    @(posedge clk); #1;
    reg_req = 1'b0;
  endtask

  task automatic wait_tx_accept(input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk); n++;
      if ((tx_tvalid && tx_tready) || n >= 500) break;
    end
    if (!(tx_tvalid && tx_tready)) begin
      checks++;
      $display("[TB] FAIL %s: got no TX accept, expected one within 500 cycles", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic reg_write(input logic [5:0] a, input logic [7:0] d);
    push_beat({2'b10, a}, 1'b0, 1'b0);
    push_beat(d, 1'b1, 1'b1);
    push_ack(8'h00, 1'b0, 1'b0);
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    @(negedge clk);
    @(negedge clk);
    checkOutput("cmd_latency", {tx_tvalid, tx_tdata}, {1'b1, 2'b10, a});
    wait_ack("write_ack");
  endtask

  task automatic reg_read(input logic [5:0] a, input logic [7:0] d, input bit noise);
    push_beat({2'b11, a}, 1'b0, 1'b0);
    push_ack(d, 1'b0, 1'b1);
    reg_req = 1'b1; reg_we = 1'b0; reg_addr = a;
    wait_tx_accept("read_cmd");
    if (noise) begin
      rx_tvalid = 1'b1; rx_tdata = 8'($urandom); rx_tuser = 2'b10;
      @(posedge clk); #1;
      rx_tvalid = 1'b0;
    end
    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    rx_tvalid = 1'b1; rx_tdata = d; rx_tuser = 2'b01;
    @(negedge clk);
    checkOutput("read_ack_early", reg_ack, 0);
    @(posedge clk); #1;
    rx_tvalid = 1'b0;
    @(negedge clk);
    checkOutput("read_ack_timing", reg_ack, 1);
    check_status();
    @(posedge clk); #1;
    reg_req = 1'b0;
  endtask

  task automatic send_pkt(input int len, input bit with_reg);
    logic [5:0] a;
    logic [7:0] d;
    bit acc;
    int i, guard;
    push_beat({4'h4, pkt_buf[0][3:0]}, len == 1, 1'b0);
    for (int k = 1; k < len; k++) push_beat(pkt_buf[k], k == len - 1, 1'b0);
    pkt_tvalid = 1'b1; pkt_tdata = pkt_buf[0]; pkt_tlast = (len == 1);
    if (with_reg) begin
      a = 6'($urandom); d = 8'($urandom);
      push_beat({2'b10, a}, 1'b0, 1'b0);
      push_beat(d, 1'b1, 1'b1);
      push_ack(8'h00, 1'b0, 1'b0);
      reg_req = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    end
    @(negedge clk);
    checkOutput("pkt_tready_decision", pkt_tready, 0);
    i = 0; guard = 0;
    while (i < len && guard < 500) begin
      @(negedge clk); acc = pkt_tready;
      @(posedge clk); #1; guard++;
      if (acc) begin
        i++;
        if (i < len) begin pkt_tdata = pkt_buf[i]; pkt_tlast = (i == len - 1); end
        else begin pkt_tvalid = 1'b0; pkt_tlast = 1'b0; end
      end
    end
    if (i < len) begin
      checks++;
      $display("[TB] FAIL pkt_accept: got %0d beats accepted, expected %0d", i, len);
      pkt_tvalid = 1'b0;
    end
    if (with_reg) wait_ack("pkt_then_reg_ack");
  endtask

  task automatic rx_status(input logic [7:0] d, input logic [1:0] user);
    rx_tvalid = 1'b1; rx_tdata = d; rx_tuser = user;
    if (user[0]) begin m_ls = d[1:0]; m_vb = d[3:2]; m_ev = d[5:4]; end
    @(posedge clk); #1;
    rx_tvalid = 1'b0;
    @(negedge clk);
    check_status();
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    reg_req = 1'b0; pkt_tvalid = 1'b0; rx_tvalid = 1'b0;
    m_ls = 2'b00; m_vb = 2'b00; m_ev = 2'b00;
    @(posedge clk); #1; @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic read_no_rx(input logic [5:0] a);
    int n;
    push_beat({2'b11, a}, 1'b0, 1'b0);
    reg_req = 1'b1; reg_we = 1'b0; reg_addr = a;
`ifdef ULPI_CTL_REG_TIMEOUT_EN
    push_ack(8'h00, 1'b1, 1'b1);
`endif
    wait_tx_accept("timeout_cmd");
    n = 0;
`ifdef ULPI_CTL_REG_TIMEOUT_EN
    forever begin
      @(negedge clk); n++;
      if (reg_ack === 1'b1 || n >= 100) break;
    end
    checkOutput("timeout_cycles", n, TMO + 1);
    @(posedge clk); #1;
    reg_req = 1'b0;
    @(posedge clk); #1;
`else
    repeat (1000) begin
      @(negedge clk);
      if (reg_ack) n++;
    end
    checkOutput("no_ack_without_timeout", n, 0);
    pulse_reset();
`endif
  endtask

  task automatic reset_in_wdata();
    rdy_mode = 2; tx_tready = 1'b1;
    push_beat({2'b10, 6'h05}, 1'b0, 1'b0);
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = 6'h05; reg_wdata = 8'hA7;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    tx_tready = 1'b0;
    @(negedge clk);
    checkOutput("wdata_beat", {tx_tvalid, tx_tlast, tx_tdata}, {1'b1, 1'b1, 8'hA7});
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_tx_tvalid", tx_tvalid, 0);
    checkOutput("rst_reg_ack", reg_ack, 0);
    reg_req = 1'b0;
    m_ls = 2'b00; m_vb = 2'b00; m_ev = 2'b00;
    @(posedge clk); #1; @(posedge clk); #1;
    rst = 1'b0; rdy_mode = 1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("no_ack_after_rst", reg_ack, 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus();
    int op, len;
    rdy_mode = $urandom_range(0, 1);
    op = $urandom_range(0, 4);
    len = $urandom_range(1, 6);
    for (int i = 0; i < len; i++) pkt_buf[i] = 8'($urandom);
    case (op)
      0: reg_write(6'($urandom), 8'($urandom));
      1: reg_read(6'($urandom), 8'($urandom), 1'($urandom));
      2: send_pkt(len, 1'b0);
      3: rx_status(8'($urandom), 2'($urandom));
      default: send_pkt(len, 1'b1);
    endcase
  endtask

  initial begin
    rst = 1'b1;
    pkt_tvalid = 1'b0; pkt_tdata = 8'h00; pkt_tlast = 1'b0;
    reg_req = 1'b0; reg_we = 1'b0; reg_addr = 6'h00; reg_wdata = 8'h00;
    rx_tvalid = 1'b0; rx_tdata = 8'h00; rx_tuser = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tx", {tx_tvalid, tx_tlast, tx_tdata}, 0);
    checkOutput("rst_pkt_tready", pkt_tready, 0);
    checkOutput("rst_reg", {reg_ack, reg_err, reg_rdata}, 0);
    check_status();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    rdy_mode = 1;
    reg_write(6'h0A, 8'h55);
    rx_status(8'h4D, 2'b01);
    checkOutput("rxcmd_4d", {rx_event, vbus_state, linestate}, 6'b00_11_01);
    reg_read(6'h16, 8'h3C, 1'b0);

    rdy_mode = 0;
    pkt_buf[0] = 8'hC3; pkt_buf[1] = 8'h11; pkt_buf[2] = 8'h22;
    send_pkt(3, 1'b0);
    pkt_buf[0] = 8'h69; pkt_buf[1] = 8'hA5;
    send_pkt(2, 1'b1);

    repeat (40) applyStimulus();

    rdy_mode = 1;
    reg_read(6'h2B, 8'hE1, 1'b0);
    read_no_rx(6'h11);
    reset_in_wdata();

    repeat (5) begin @(posedge clk); #1; end
    checkOutput("tx_queue_empty", exp_tx.size(), 0);
    checkOutput("ack_queue_empty", exp_ack.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
